// File: rtl/i2c_txn_sched.sv
// Round-robin scheduler that shares one i2c_master among NUM_REQ three-byte write requesters.
// It also retries NACKs, times out hung transactions, and returns completion status to the granted requester.
module i2c_txn_sched #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_RETRY  = 2,
  parameter int GAP_CYCLES = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*7-1:0]    req_addr,
  input  logic [NUM_REQ*16-1:0]   req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      req_done,
  output logic [1:0]              req_err,
  output logic                    m_start,
  output logic [6:0]              m_addr,
  output logic [7:0]              m_data1,
  output logic [7:0]              m_data2,
  input  logic                    m_busy,
  input  logic                    m_done,
  input  logic                    m_nack,
  output logic                    m_abort
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int RTY_W = ($clog2(MAX_RETRY + 1) > 2) ? $clog2(MAX_RETRY + 1) : 2;
  localparam int TO_W  = $clog2(TIMEOUT);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   last, last_n;
  logic [RTY_W-1:0]   retry_cnt, retry_n;
  logic [TO_W-1:0]    to_cnt, to_n;
  logic [GAP_W-1:0]   gap_cnt, gap_n;
  logic [NUM_REQ-1:0] grant_n, done_n;
  logic [1:0]         err_n;
  logic               start_n, abort_n;
  logic [6:0]         addr_n;
  logic [7:0]         data1_n, data2_n;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               fin;
  logic [1:0]         fin_status;

  // Search upward from the requester after the last winner, wrapping modulo NUM_REQ
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req[(int'(last) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    done_n     = '0;
    err_n      = '0;
    start_n    = 1'b0;
    abort_n    = 1'b0;
    addr_n     = m_addr;
    data1_n    = m_data1;
    data2_n    = m_data2;
    last_n     = last;
    retry_n    = retry_cnt;
    to_n       = to_cnt;
    gap_n      = gap_cnt;
    fin        = 1'b0;
    fin_status = 2'd0;
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_n = NUM_REQ'(1) << win_idx;
          addr_n  = req_addr[7*int'(win_idx) +: 7];
          data1_n = req_data[16*int'(win_idx) + 8 +: 8];
          data2_n = req_data[16*int'(win_idx) +: 8];
          last_n  = win_idx;
          retry_n = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!m_busy) begin
          start_n = 1'b1;
          to_n    = '0;
          state_n = WAIT;
        end
      end
      WAIT: begin
        // A completing m_done takes precedence over a timeout on the same cycle
        if (m_done) begin
          if (!m_nack) begin
            fin = 1'b1;
          end else if (retry_cnt < RTY_W'(MAX_RETRY)) begin
            retry_n = retry_cnt + RTY_W'(1);
            gap_n   = '0;
            state_n = GAP;
          end else begin
            fin        = 1'b1;
            fin_status = 2'd1;
          end
        end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
          abort_n    = 1'b1;
          fin        = 1'b1;
          fin_status = 2'd2;
        end else if (to_cnt != {TO_W{1'b1}}) begin
          to_n = to_cnt + TO_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
          state_n = ISSUE;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    if (fin) begin
      done_n  = grant;
      err_n   = fin_status;
      grant_n = '0;
      state_n = IDLE;
    end
  end

  // The reset value of last gives requester 0 first priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      req_done  <= '0;
      req_err   <= '0;
      m_start   <= 1'b0;
      m_abort   <= 1'b0;
      m_addr    <= '0;
      m_data1   <= '0;
      m_data2   <= '0;
      last      <= IDX_W'(NUM_REQ - 1);
      retry_cnt <= '0;
      to_cnt    <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      req_done  <= done_n;
      req_err   <= err_n;
      m_start   <= start_n;
      m_abort   <= abort_n;
      m_addr    <= addr_n;
      m_data1   <= data1_n;
      m_data2   <= data2_n;
      last      <= last_n;
      retry_cnt <= retry_n;
      to_cnt    <= to_n;
      gap_cnt   <= gap_n;
    end
  end

endmodule

// File: tb/tb_i2c_txn_sched.sv
// Bench for i2c_txn_sched: a timestamp-based transaction model plus directed scenarios.
// The scenarios are single write, round-robin, NACK retry, timeout, busy hold-off, and reset mid-transaction.
module tb_i2c_txn_sched;

  localparam int NUM_REQ    = 4;
  localparam int MAX_RETRY  = 2;
  localparam int GAP_CYCLES = 16;
  localparam int TIMEOUT    = 4096;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ*7-1:0]  req_addr = '0;
  logic [NUM_REQ*16-1:0] req_data = '0;
  logic [NUM_REQ-1:0]    grant, req_done;
  logic [1:0]            req_err;
  logic                  m_start, m_abort;
  logic [6:0]            m_addr;
  logic [7:0]            m_data1, m_data2;
  logic                  m_busy = 1'b0;
  logic                  m_done = 1'b0;
  logic                  m_nack = 1'b0;

  always #5 clk = ~clk;

  i2c_txn_sched #(
    .NUM_REQ(NUM_REQ), .MAX_RETRY(MAX_RETRY), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .grant(grant), .req_done(req_done), .req_err(req_err),
    .m_start(m_start), .m_addr(m_addr), .m_data1(m_data1), .m_data2(m_data2),
    .m_busy(m_busy), .m_done(m_done), .m_nack(m_nack), .m_abort(m_abort)
  );

  int   checks = 0;
  int   errors = 0;
  int   now = 0;
  int   lat_cfg = 3;
  int   nack_cfg = 0;
  logic hang_cfg = 1'b0;

  logic [NUM_REQ-1:0] prev_grant = '0;
  logic [NUM_REQ-1:0] grant_log[$];
  int                 grant_ticks[$];
  int                 start_ticks[$];
  int                 mdone_ticks[$];

  // Reference model: tracks each transaction by absolute edge timestamps
  localparam int PH_IDLE = 0, PH_NEED_START = 1, PH_AWAIT = 2, PH_GAP = 3;
  logic [NUM_REQ-1:0] exp_grant = '0, exp_done = '0;
  logic [1:0]         exp_err = '0;
  logic               exp_start = 1'b0, exp_abort = 1'b0;
  logic [6:0]         exp_addr = '0;
  logic [7:0]         exp_d1 = '0, exp_d2 = '0;
  int md_cyc = 0, md_last = NUM_REQ - 1, md_phase = PH_IDLE, md_retries = 0;
  int md_t_start = 0, md_t_gap_end = 0, md_fin = -1, md_w = -1;

  initial forever begin
    @(posedge clk);
    md_cyc++;
    exp_start = 1'b0;
    exp_abort = 1'b0;
    exp_done  = '0;
    md_fin    = -1;
    if (rst) begin
      exp_grant = '0; exp_err = '0; exp_addr = '0; exp_d1 = '0; exp_d2 = '0;
      md_last = NUM_REQ - 1; md_phase = PH_IDLE;
    end else begin
      case (md_phase)
        PH_IDLE: begin
          md_w = -1;
          for (int k = 1; k <= NUM_REQ; k++) begin
            if (md_w < 0 && req[(md_last + k) % NUM_REQ]) md_w = (md_last + k) % NUM_REQ;
          end
          if (md_w >= 0) begin
            exp_grant  = NUM_REQ'(1) << md_w;
            exp_addr   = req_addr[7*md_w +: 7];
            exp_d1     = req_data[16*md_w + 8 +: 8];
            exp_d2     = req_data[16*md_w +: 8];
            md_last    = md_w;
            md_retries = 0;
            md_phase   = PH_NEED_START;
          end
        end
        PH_NEED_START: begin
          if (!m_busy) begin
            exp_start  = 1'b1;
            md_t_start = md_cyc;
            md_phase   = PH_AWAIT;
          end
        end
        PH_AWAIT: begin
          if (m_done) begin
            if (!m_nack) md_fin = 0;
            else if (md_retries < MAX_RETRY) begin
              md_retries++;
              md_t_gap_end = md_cyc + GAP_CYCLES;
              md_phase = PH_GAP;
            end else md_fin = 1;
          end else if (md_cyc - md_t_start == TIMEOUT) begin
            exp_abort = 1'b1;
            md_fin = 2;
          end
        end
        default: if (md_cyc == md_t_gap_end) md_phase = PH_NEED_START;
      endcase
      if (md_fin >= 0) begin
        exp_done  = exp_grant;
        exp_err   = 2'(md_fin);
        exp_grant = '0;
        md_phase  = PH_IDLE;
      end
    end
  end

  // Master model: answers each m_start after lat_cfg cycles, NACKing the first nack_cfg attempts
  int resp_cnt = 0, nacks_given = 0;
  initial forever begin
    @(negedge clk);
    m_done = 1'b0;
    m_nack = 1'b0;
    if (rst) begin
      resp_cnt = 0;
      nacks_given = 0;
    end else begin
      if (req_done != '0) nacks_given = 0;
      if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          m_done = 1'b1;
          m_nack = (nacks_given < nack_cfg);
          if (m_nack) nacks_given++;
        end
      end
      if (m_start && !hang_cfg) resp_cnt = lat_cfg;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: actual %0h required %0h (tick %0d)", name, act, expv, now);
    end
  endtask

  task automatic checkOutput();
    check("grant", 64'(grant), 64'(exp_grant));
    check("req_done", 64'(req_done), 64'(exp_done));
    check("m_start", 64'(m_start), 64'(exp_start));
    check("m_abort", 64'(m_abort), 64'(exp_abort));
    if (exp_done != '0) check("req_err", 64'(req_err), 64'(exp_err));
    if (exp_grant != '0) begin
      check("m_addr", 64'(m_addr), 64'(exp_addr));
      check("m_data1", 64'(m_data1), 64'(exp_d1));
      check("m_data2", 64'(m_data2), 64'(exp_d2));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    now++;
    checkOutput();
    if (grant != '0 && prev_grant == '0) begin
      grant_log.push_back(grant);
      grant_ticks.push_back(now);
    end
    prev_grant = grant;
    if (m_start) start_ticks.push_back(now);
    if (m_done) mdone_ticks.push_back(now);
  endtask

  task automatic applyStimulus(input int idx, input logic [6:0] a, input logic [15:0] d);
    req_addr[7*idx +: 7]   = a;
    req_data[16*idx +: 16] = d;
  endtask

  task automatic clearLogs();
    grant_log.delete();
    grant_ticks.delete();
    start_ticks.delete();
    mdone_ticks.delete();
  endtask

  task automatic runTxn(input int budget, input logic drop, output logic [NUM_REQ-1:0] done_v,
                        output logic [1:0] err_v, output int done_tick);
    logic fin;
    fin = 1'b0;
    done_v = '0;
    err_v = '0;
    done_tick = -1;
    for (int k = 0; k < budget && !fin; k++) begin
      tick();
      if (req_done != '0) begin
        done_v = req_done;
        err_v = req_err;
        done_tick = now;
        fin = 1'b1;
        if (drop) req = req & ~req_done;
      end
    end
    check("txn_completed", 64'(fin), 64'd1);
  endtask

  logic [NUM_REQ-1:0] rr_order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    logic [NUM_REQ-1:0] dv;
    logic [1:0] ev;
    int dt, d0, fall;

    rst = 1'b1;
    tick();
    tick();
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_pulses", 64'({req_done, req_err, m_start, m_abort}), 64'd0);
    check("rst_payload", 64'({m_addr, m_data1, m_data2}), 64'd0);
    rst = 1'b0;
    tick();

    $display("[TB] single write");
    clearLogs();
    lat_cfg = 4; nack_cfg = 0; hang_cfg = 1'b0;
    applyStimulus(1, 7'h50, 16'hA53C);
    req = 4'b0010;
    tick();
    check("sw_grant", 64'(grant), 64'h2);
    check("sw_addr", 64'(m_addr), 64'h50);
    check("sw_data1", 64'(m_data1), 64'hA5);
    check("sw_data2", 64'(m_data2), 64'h3C);
    applyStimulus(1, 7'h7F, 16'hFFFF);
    runTxn(100, 1'b1, dv, ev, dt);
    check("sw_done", 64'(dv), 64'h2);
    check("sw_err", 64'(ev), 64'd0);
    check("sw_starts", 64'(start_ticks.size()), 64'd1);
    check("sw_addr_held", 64'(m_addr), 64'h50);
    if (start_ticks.size() > 0 && grant_ticks.size() > 0)
      check("sw_start_lat", 64'(start_ticks[0] - grant_ticks[0]), 64'd1);
    if (mdone_ticks.size() > 0) check("sw_done_lat", 64'(dt - mdone_ticks[0]), 64'd1);

    $display("[TB] round robin");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clearLogs();
    lat_cfg = 2;
    for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 7'(32'h10 + i), 16'(32'h2030 + 32'h0101 * i));
    req = 4'b1111;
    d0 = 0;
    for (int t = 0; t < 5; t++) begin
      runTxn(200, 1'b0, dv, ev, dt);
      check("rr_done", 64'(dv), 64'(rr_order[t]));
      if (t == 0) d0 = dt;
    end
    req = '0;
    check("rr_grants", 64'(grant_log.size()), 64'd5);
    for (int t = 0; t < 5 && t < grant_log.size(); t++) check("rr_order", 64'(grant_log[t]), 64'(rr_order[t]));
    if (start_ticks.size() > 1) check("rr_b2b", 64'(start_ticks[1] - d0), 64'd2);

    $display("[TB] nack retry");
    clearLogs();
    lat_cfg = 3; nack_cfg = 2;
    applyStimulus(3, 7'h2A, 16'h1234);
    req = 4'b1000;
    runTxn(300, 1'b1, dv, ev, dt);
    check("nk2_done", 64'(dv), 64'h8);
    check("nk2_err", 64'(ev), 64'd0);
    check("nk2_starts", 64'(start_ticks.size()), 64'd3);
    for (int i = 0; i < 2 && i + 1 < start_ticks.size() && i < mdone_ticks.size(); i++)
      check("nk2_spacing", 64'(start_ticks[i+1] - (mdone_ticks[i] + 1)), 64'd17);
    clearLogs();
    nack_cfg = 3;
    req = 4'b1000;
    runTxn(300, 1'b1, dv, ev, dt);
    check("nk3_done", 64'(dv), 64'h8);
    check("nk3_err", 64'(ev), 64'd1);
    check("nk3_starts", 64'(start_ticks.size()), 64'd3);
    if (mdone_ticks.size() > 2) check("nk3_done_lat", 64'(dt - mdone_ticks[2]), 64'd1);
    nack_cfg = 0;

    $display("[TB] timeout");
    clearLogs();
    hang_cfg = 1'b1;
    applyStimulus(0, 7'h11, 16'hBEEF);
    req = 4'b0001;
    runTxn(TIMEOUT + 200, 1'b1, dv, ev, dt);
    check("to_done", 64'(dv), 64'h1);
    check("to_err", 64'(ev), 64'd2);
    check("to_abort", 64'(m_abort), 64'd1);
    check("to_grant", 64'(grant), 64'd0);
    check("to_starts", 64'(start_ticks.size()), 64'd1);
    if (start_ticks.size() > 0) check("to_dist", 64'(dt - start_ticks[0]), 64'd4096);

    $display("[TB] busy hold-off");
    clearLogs();
    hang_cfg = 1'b0;
    applyStimulus(2, 7'h3B, 16'h5AC3);
    m_busy = 1'b1;
    req = 4'b0100;
    tick();
    check("bz_grant", 64'(grant), 64'h4);
    for (int k = 0; k < 10; k++) tick();
    check("bz_suppressed", 64'(start_ticks.size()), 64'd0);
    m_busy = 1'b0;
    fall = now;
    runTxn(100, 1'b1, dv, ev, dt);
    check("bz_err", 64'(ev), 64'd0);
    if (start_ticks.size() > 0) check("bz_start", 64'(start_ticks[0] - fall), 64'd1);

    $display("[TB] reset mid-wait");
    clearLogs();
    hang_cfg = 1'b1;
    req = 4'b0100;
    for (int k = 0; k < 10 && start_ticks.size() == 0; k++) tick();
    check("rs_started", 64'(start_ticks.size()), 64'd1);
    for (int k = 0; k < 5; k++) tick();
    rst = 1'b1;
    tick();
    check("rs_grant", 64'(grant), 64'd0);
    check("rs_pulses", 64'({req_done, req_err, m_start, m_abort}), 64'd0);
    check("rs_payload", 64'({m_addr, m_data1, m_data2}), 64'd0);
    rst = 1'b0;
    hang_cfg = 1'b0;
    clearLogs();
    req = 4'b0101;
    runTxn(100, 1'b1, dv, ev, dt);
    req = '0;
    if (grant_log.size() > 0) check("rs_next_grant", 64'(grant_log[0]), 64'h1);
    check("rs_done", 64'(dv), 64'h1);
    for (int k = 0; k < 4; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_txn_sched.md
# i2c_txn_sched

Transaction scheduler that shares one `i2c_master` core among `NUM_REQ` requesters, each wanting a 3-byte write: slave address plus two data bytes. Grants are round-robin. The winner's payload is latched and the master is started. NACKs are retried, hung transactions are timed out, and completion status goes back to the granted requester. Sits between system-side requesters and the `i2c_master` command interface.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_RETRY`, 2: re-issues allowed after a NACK before reporting an error.
- `GAP_CYCLES`, 16: idle cycles between a NACK and its re-issue.
- `TIMEOUT`, 4096: cycles allowed from `m_start` to `m_done`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `req` in NUM_REQ: level request per requester; held until its `req_done`.
- `req_addr` in NUM_REQ*7: 7-bit slave address per requester; requester i at bits [7i+6:7i].
- `req_data` in NUM_REQ*16: per requester, {data1, data2}; requester i at [16i+15:16i]; data1 is sent first.
- `grant` out NUM_REQ: one-hot, the requester currently owning the master.
- `req_done` out NUM_REQ: one-cycle pulse on the granted bit at completion.
- `req_err` out 2: valid with `req_done`; 0 = OK, 1 = NACK after retries, 2 = timeout.
- `m_start` out 1: one-cycle start pulse to the master.
- `m_addr` out 7: address to the master, held stable from `m_start` until `m_done`.
- `m_data1`, `m_data2` out 8 each: data bytes to the master, held stable from `m_start` until `m_done`.
- `m_busy` in 1: master busy.
- `m_done` in 1: one-cycle completion pulse from the master.
- `m_nack` in 1: valid with `m_done`; any byte NACKed.
- `m_abort` out 1: one-cycle pulse on timeout; the master returns to idle.

## Operation
- States: IDLE, ISSUE, WAIT, GAP.
- IDLE
  - If `req` != 0, pick the first set bit searching upward from `last+1` (mod NUM_REQ).
  - Set `grant`, latch that requester's addr/data into `m_*`, `last` <= winner, clear the retry counter, go to ISSUE.
- ISSUE
  - While `m_busy`=1: stay, no pulse.
  - Else: `m_start`=1 for one cycle, clear the timeout counter, go to WAIT.
- WAIT: the timeout counter increments each cycle.
  - `m_done` and !`m_nack`: complete with status 0.
  - `m_done` and `m_nack`, retry count < MAX_RETRY: increment the retry count, go to GAP.
  - `m_done` and `m_nack`, retries exhausted: complete with status 1.
  - Counter reaches TIMEOUT-1 without `m_done`: pulse `m_abort`, complete with status 2.
  - `m_done` and timeout in the same cycle: `m_done` wins.
- GAP: count GAP_CYCLES cycles, then go to ISSUE with the same latched payload.
- Complete: on one edge, `req_done[g]`<=1, `req_err`<=status, `grant`<=0, state<=IDLE.
- `req` dropped mid-transaction: ignored. The transaction runs to completion and `req_done` still pulses.
- `req` changes after grant: ignored, because the payload is latched.
- Retry count is 2 bits minimum, width $clog2(MAX_RETRY+1).
- Timeout counter width is $clog2(TIMEOUT). It saturates and never wraps.

## Timing
- Reset values:
  - state IDLE.
  - `grant`, `req_done`, `req_err`, `m_start`, `m_abort` all 0.
  - `m_addr`, `m_data1`, `m_data2` all 0.
  - `last` = NUM_REQ-1, so requester 0 has first priority after reset.
- Reset mid-transaction: all outputs return to reset values on the next edge. No `req_done` is issued for the aborted transaction.
- Latency, with `m_busy`=0 and `req` sampled high at edge E:
  - `grant` and `m_*` valid after E.
  - `m_start` high for the cycle after E+1.
  - `m_done` sampled at edge D: `req_done` high for the cycle after D, and `grant` falls at D.
- Back-to-back: IDLE in the cycle after completion can grant again. Minimum is 2 cycles from `req_done` to the next `m_start`.
- Retry spacing: the `m_start` re-issue occurs GAP_CYCLES+1 cycles after the NACKing `m_done` edge.
- Outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Single write: requester 1 sends addr 0x50, data 0xA5/0x3C. Master model completes OK. Expect:
  - `m_addr`=0x50, `m_data1`=0xA5, `m_data2`=0x3C.
  - Exactly one `m_start`.
  - `req_done`=4'b0010 with `req_err`=0.
- Round-robin: all four `req` held high continuously. Grant order is 0,1,2,3,0. No `grant` overlap, and each `req_done` matches the grant.
- NACK retry: master NACKs twice, then ACKs. Expect 3 `m_start` pulses spaced 17 cycles after each `m_done`, ending with `req_err`=0. With 3 NACKs: `req_err`=1 after the 3rd `m_done`.
- Timeout: master never pulses `m_done`. Expect `m_abort` 4096 cycles after `m_start`, `req_err`=2, and `grant` cleared.
- Busy hold-off: `m_busy`=1 for 10 cycles after grant. `m_start` is suppressed, then fires in the first cycle after `m_busy` falls.
- Reset mid-WAIT: assert `rst` for one cycle. All outputs go to 0 on the next edge, no `req_done`, and the next grant goes to requester 0.
